byte_serializer: RTL

- Buffers bytes from a valid/ready producer and shifts each out as a framed serial bit stream on a single line: start bit, 8 data bits, stop bit.
- Sits directly upstream of my_module. ser_out drives the `one` signal of my_interface1 (sys modport input).
- Bit timing comes from an external strobe, so one block serves any line rate.

---
 rtl/byte_ser_pkg.sv | 21 ++
 rtl/byte_serializer_if.sv | 12 +
 rtl/byte_ser_fifo.sv | 66 ++++++
 rtl/byte_serializer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/byte_ser_pkg.sv
// rtl/byte_ser_pkg.sv - shared types and line levels for byte_serializer
// BYTE_SER_PARITY_EN adds the PARITY state to the frame FSM.
package byte_ser_pkg;

  typedef logic [7:0] t_byte;

`ifdef BYTE_SER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} t_ser_state;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} t_ser_state;
`endif

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic logic even_parity(input t_byte b);
    return ^b;
  endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// rtl/byte_serializer_if.sv - valid/ready byte producer handshake
interface byte_serializer_if;
  import byte_ser_pkg::*;

  t_byte in_data;
  logic  in_valid;
  logic  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/byte_ser_fifo.sv
// rtl/byte_ser_fifo.sv - DEPTH-entry byte FIFO; refused push when full, pop ignored when empty
module byte_ser_fifo
  import byte_ser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  t_byte                      wr_data,
  input  logic                       pop,
  output t_byte                      rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  t_byte          mem_q [DEPTH];
  t_byte          mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - FIFO-buffered start/8 data/stop serializer paced by bit_en
// BYTE_SER_PARITY_EN inserts an even parity bit before the stop bit.
module byte_serializer
  import byte_ser_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  byte_serializer_if.slave           in_if,
  input  logic                       bit_en,
  output logic                       ser_out,
  output logic                       ser_busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow
);

  t_ser_state state_q, state_d;
  t_byte      shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       ser_out_q, ser_out_d;
  logic       overflow_q, overflow_d;
  logic       pop, full, empty;
  t_byte      head;
  logic       next_bit;
  t_byte      shifted;
`ifdef BYTE_SER_PARITY_EN
  logic       parity_q, parity_d;
`endif

  byte_ser_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_if.in_valid),
    .wr_data (in_if.in_data),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  assign in_if.in_ready = ~full;
  assign ser_out        = ser_out_q;
  assign ser_busy       = (state_q != IDLE);
  assign overflow       = overflow_q;
  assign next_bit       = LSB_FIRST ? shreg_q[0] : shreg_q[7];
  assign shifted        = LSB_FIRST ? {1'b0, shreg_q[7:1]} : {shreg_q[6:0], 1'b0};

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    ser_out_d  = ser_out_q;
    pop        = 1'b0;
    overflow_d = overflow_q | (in_if.in_valid & full);
`ifdef BYTE_SER_PARITY_EN
    parity_d   = parity_q;
`endif
    if (bit_en) begin
      case (state_q)
        IDLE, STOP: begin
          // a waiting byte starts immediately after a stop bit: no idle gap
          if (!empty) begin
            pop       = 1'b1;
            shreg_d   = head;
`ifdef BYTE_SER_PARITY_EN
            parity_d  = even_parity(head);
`endif
            ser_out_d = START_BIT;
            state_d   = START;
          end else begin
            ser_out_d = LINE_IDLE;
            state_d   = IDLE;
          end
        end
        START: begin
          ser_out_d = next_bit;
          shreg_d   = shifted;
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_cnt_q == 3'd7) begin
`ifdef BYTE_SER_PARITY_EN
            ser_out_d = parity_q;
            state_d   = PARITY;
`else
            ser_out_d = STOP_BIT;
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            ser_out_d = next_bit;
            shreg_d   = shifted;
          end
        end
`ifdef BYTE_SER_PARITY_EN
        PARITY: begin
          ser_out_d = STOP_BIT;
          state_d   = STOP;
        end
`endif
        default: begin
          ser_out_d = LINE_IDLE;
          state_d   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      ser_out_q  <= LINE_IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      ser_out_q  <= ser_out_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef BYTE_SER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule
